// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// The owner is tracked as a binary index; the one-hot grant is its decode.
// A tenure ends when the owner drops its request or, if enabled, when it hits the hold limit.
// After every release the search pointer moves past the old owner and one idle bubble follows.
module rr_arbiter8 #(
    parameter int unsigned NREQ     = 8,
    parameter int unsigned IDXW     = 3,
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNTW     = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_valid_o,
    output logic            timeout_o
);

    typedef enum logic {StIdle, StGrant} state_e;

    // Last hold count value before a forced release; unused when MAX_HOLD is 0.
    localparam int unsigned     HoldLastInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNTW-1:0] HoldLast    = CNTW'(HoldLastInt);
    localparam bit              HoldEn      = (MAX_HOLD != 0);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;

    logic [IDXW-1:0]   winner;
    logic [IDXW-1:0]   cand;
    logic              found;
    logic              owner_req;
    logic              limit_hit;

    // Rotating priority search starting at ptr_q; the first set request wins.
    always_comb begin
        winner = ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr_q + IDXW'(i);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_req = req_i[owner_q];
    assign limit_hit = HoldEn && (hold_cnt_q == HoldLast);

    // Next-state logic: arbitration in idle, tenure tracking and release while granted.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StGrant;
                    owner_d    = winner;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end
                // A dropped request takes precedence, so a drop on the limit edge is not a timeout.
                if (!owner_req || limit_hit) begin
                    state_d    = StIdle;
                    ptr_d      = owner_q + IDXW'(1);
                    hold_cnt_d = '0;
                    timeout_d  = owner_req;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet track the state edge.
    always_comb begin
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        if (state_d == StGrant) begin
            grant_d[owner_d] = 1'b1;
            grant_idx_d      = owner_d;
            grant_valid_d    = 1'b1;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            owner_q       <= '0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = grant_idx_q;
    assign grant_valid_o = grant_valid_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: default, short-hold and unlimited-hold instances.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req_a, req_b, req_c;
    logic [7:0] grant_a, grant_b, grant_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       valid_a, valid_b, valid_c;
    logic       to_a, to_b, to_c;

    int errors = 0;
    int checks = 0;

    rr_arbiter8 #(.MAX_HOLD(15), .CNTW(4)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .grant_o(grant_a),
        .grant_idx_o(idx_a), .grant_valid_o(valid_a), .timeout_o(to_a)
    );

    rr_arbiter8 #(.MAX_HOLD(4), .CNTW(4)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .grant_o(grant_b),
        .grant_idx_o(idx_b), .grant_valid_o(valid_b), .timeout_o(to_b)
    );

    rr_arbiter8 #(.MAX_HOLD(0), .CNTW(4)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req_c), .grant_o(grant_c),
        .grant_idx_o(idx_c), .grant_valid_o(valid_c), .timeout_o(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample point is 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_g;

        // Reset with every requester active.
        rst   = 1'b1;
        req_a = 8'hFF;
        req_b = 8'hFF;
        req_c = 8'hFF;
        tick();
        tick();
        chk("rst_grant", grant_a, 8'h00);
        chk("rst_idx", {5'd0, idx_a}, 8'h00);
        chk("rst_valid", {7'd0, valid_a}, 8'h00);
        chk("rst_timeout", {7'd0, to_a}, 8'h00);
        chk("rst_grant_b", grant_b, 8'h00);
        req_a = 8'h00;
        req_b = 8'h00;
        req_c = 8'h00;
        rst   = 1'b0;
        tick();

        // Single request from requester 5, then drop.
        req_a = 8'h20;
        tick();
        chk("single_grant", grant_a, 8'h20);
        chk("single_idx", {5'd0, idx_a}, 8'h05);
        chk("single_valid", {7'd0, valid_a}, 8'h01);
        req_a = 8'h00;
        tick();
        chk("single_drop_grant", grant_a, 8'h00);
        chk("single_drop_valid", {7'd0, valid_a}, 8'h00);
        chk("single_drop_to", {7'd0, to_a}, 8'h00);

        // Wrap: owner 6 releases (ptr=7), then requesters 0 and 1.
        req_a = 8'h40;
        tick();
        chk("wrap_own6", grant_a, 8'h40);
        req_a = 8'h03;
        tick();
        chk("wrap_release", grant_a, 8'h00);
        tick();
        chk("wrap_grant0", grant_a, 8'h01);
        chk("wrap_idx0", {5'd0, idx_a}, 8'h00);
        req_a = 8'h02;
        tick();
        chk("wrap_bubble", grant_a, 8'h00);
        tick();
        chk("wrap_grant1", grant_a, 8'h02);
        chk("wrap_idx1", {5'd0, idx_a}, 8'h01);

        // Move ownership to 3, then reset between edges.
        req_a = 8'h08;
        tick();
        tick();
        chk("pre_rst_own3", grant_a, 8'h08);
        #2 rst = 1'b1;
        #1;
        chk("midrst_grant", grant_a, 8'h00);
        chk("midrst_valid", {7'd0, valid_a}, 8'h00);
        chk("midrst_idx", {5'd0, idx_a}, 8'h00);
        #1 rst = 1'b0;
        req_a = 8'h88;
        tick();
        chk("postrst_grant", grant_a, 8'h08);
        chk("postrst_idx", {5'd0, idx_a}, 8'h03);
        req_a = 8'h00;

        // Fairness with hold limit 4: owners 0..7,0, forced release with timeout each time.
        req_b = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("fair_grant_k%0d_c%0d", k, c), grant_b, exp_g);
                chk($sformatf("fair_to_k%0d_c%0d", k, c), {7'd0, to_b}, 8'h00);
            end
            tick();
            chk($sformatf("fair_bubble_k%0d", k), grant_b, 8'h00);
            chk($sformatf("fair_timeout_k%0d", k), {7'd0, to_b}, 8'h01);
        end
        tick();
        chk("fair_next_owner1", grant_b, 8'h02);
        chk("fair_to_cleared", {7'd0, to_b}, 8'h00);
        req_b = 8'h00;
        tick();
        chk("fair_normal_rel", grant_b, 8'h00);
        chk("fair_normal_to", {7'd0, to_b}, 8'h00);

        // Drop on the same edge the limit is hit: ordinary release, no timeout.
        req_b = 8'h04;
        tick();
        tick();
        tick();
        tick();
        chk("edge_hold", grant_b, 8'h04);
        req_b = 8'h00;
        tick();
        chk("edge_rel_grant", grant_b, 8'h00);
        chk("edge_rel_to", {7'd0, to_b}, 8'h00);

        // Lone requester held: forced off, re-granted after one bubble.
        req_b = 8'h10;
        tick();
        chk("lone_grant", grant_b, 8'h10);
        chk("lone_idx", {5'd0, idx_b}, 8'h04);
        tick();
        tick();
        tick();
        tick();
        chk("lone_forced", grant_b, 8'h00);
        chk("lone_timeout", {7'd0, to_b}, 8'h01);
        tick();
        chk("lone_regrant", grant_b, 8'h10);
        chk("lone_to_clr", {7'd0, to_b}, 8'h00);
        req_b = 8'h00;

        // Unlimited hold: grant persists, timeout never fires.
        req_c = 8'h01;
        tick();
        for (int n = 0; n < 100; n++) begin
            chk($sformatf("unl_grant_%0d", n), grant_c, 8'h01);
            chk($sformatf("unl_to_%0d", n), {7'd0, to_c}, 8'h00);
            tick();
        end
        chk("unl_valid", {7'd0, valid_c}, 8'h01);
        req_c = 8'h00;
        tick();
        chk("unl_release", grant_c, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
